s2_pipe: RTL and testbench
==========================

Name: s2_pipe

Overview:
- Parametrised, multi-bit successor of the single-bit S2 select-and-register cell.
- For each bit lane, selects one of four data inputs using S1 = A1|B1 and S0 = A0&B0, as the S2 cell does.
- The selected word then travels through a DEPTH-stage register pipeline with a valid bit, a global advance enable and a saturating delivered-word counter.
- Used as the registered operand/partial-product selector stage feeding the MAC datapath.

Parameters:
- WIDTH, 8, number of bit lanes (data and select width); legal range >= 1.
- DEPTH, 2, number of register stages from mux output to OUT; legal range >= 1.
- CNT_W, 8, width of the delivered-word counter OUT_CNT; legal range >= 1.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- CLR  input  1  reset, synchronous, active-high.
- EN  input  1  advance enable; 1 = all stages shift, 0 = all stages hold.
- IN_VALID  input  1  marks the word presented this cycle as valid.
- D0, D1, D2, D3  input  WIDTH  candidate data words.
- A1, B1  input  WIDTH  per-lane OR terms forming S1.
- A0, B0  input  WIDTH  per-lane AND terms forming S0.
- OUT  output  WIDTH  final pipeline stage data.
- OUT_VALID  output  1  valid bit of the final stage.
- OUT_CNT  output  CNT_W  count of valid words delivered to OUT, saturating.

Behaviour:
- Per-lane select, for each lane i:
  - S1[i] = A1[i]|B1[i]; S0[i] = A0[i]&B0[i].
  - Selected bit is D0[i], D1[i], D2[i] or D3[i] for {S1,S0} = 00, 01, 10, 11 respectively.
  - The mux is purely combinational and feeds stage 0.
- Pipeline stages: stage 0 .. stage DEPTH-1. Each stage holds a data word and a valid bit. OUT and OUT_VALID are stage DEPTH-1 directly; there is no combinational path from any input to OUT.
- EN=1 on an edge:
  - Stage 0 captures the mux result and IN_VALID.
  - Stage k captures stage k-1 for k >= 1.
- EN=0 on an edge: every stage holds its data and valid bit; IN_VALID and the data inputs are ignored.
- Latency:
  - A word presented with EN=1 appears on OUT after exactly DEPTH enabled edges.
  - Disabled edges add delay but never reorder, drop or duplicate words.
- Invalid words flow through the pipeline. Their data is still captured (it is not forced to zero) and OUT_VALID=0 while they occupy the last stage.
- OUT_CNT:
  - Increments by 1 on an edge where EN=1 and the word entering the last stage is valid (stage DEPTH-2 valid, or IN_VALID when DEPTH=1). It therefore updates on the same edge that OUT_VALID goes high for that word.
  - Saturates at 2^CNT_W-1; no wrap.
  - Holds when EN=0.
- Reset:
  - CLR=1 on an edge sets all stage data to 0, all valid bits to 0 and OUT_CNT to 0.
  - CLR has priority over EN and takes effect mid-operation: in-flight words are discarded.
  - First valid output after CLR falls comes no earlier than DEPTH enabled edges later.
- Reset values: OUT=0, OUT_VALID=0, OUT_CNT=0.
- DEPTH=1: the single stage is both stage 0 and the output stage.

Optional Feature:
- Macro: S2_PIPE_PARITY_EN.
- Defined:
  - Adds output port OUT_PAR (1 bit) equal to the even parity (XOR reduction) of the word in the last stage.
  - Parity is computed from the mux output at stage 0 and pipelined alongside the data with the same EN/CLR rules.
  - Reset value is 0.
- Not defined: the OUT_PAR port and its pipeline registers do not exist. All other behaviour is identical.

Test Plan:
- Reset: WIDTH=8, DEPTH=2. Hold CLR=1 for 2 edges with EN=1, IN_VALID=1, all inputs 0xFF -> OUT=0x00, OUT_VALID=0, OUT_CNT=0.
- All-ones select: A1=B1=A0=B0=0xFF, D3=0xA5, D0=D1=D2=0x00, IN_VALID=1, EN=1 for 1 edge, then IN_VALID=0 -> OUT=0xA5 with OUT_VALID=1 after the 2nd edge; OUT_VALID=0 on the 3rd; OUT_CNT=1.
- Per-lane mix: A1=0xF0, B1=0x00, A0=0xCC, B0=0xAA.
  - With D3=0xFF and D0=D1=D2=0x00 -> OUT=0x80 after 2 edges.
  - With D0=0xFF and D1=D2=D3=0x00 -> OUT=0x07.
- Stall: stream words 0x11, 0x22, 0x33; drop EN=0 for 3 edges after the 2nd word enters -> OUT, OUT_VALID and OUT_CNT frozen during the stall; after resume OUT shows 0x11, 0x22, 0x33 in order and OUT_CNT=3.
- Saturation: CNT_W=4, 20 consecutive valid words with EN=1 -> OUT_CNT reaches 15 and stays 15.
- Reset mid-flight: 2 valid words in the pipeline, CLR=1 for 1 edge -> OUT=0x00, OUT_VALID=0, OUT_CNT=0; neither discarded word ever appears on OUT. With S2_PIPE_PARITY_EN defined, OUT_PAR=0 after reset and OUT_PAR=0 for 0xA5.

Source files
------------

// File: rtl/s2_pipe.sv
// s2_pipe: per-lane S2-style four-way select feeding a DEPTH-stage valid pipeline
// with a saturating delivered-word counter. Optional OUT_PAR via `S2_PIPE_PARITY_EN.
module s2_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             EN,
  input  logic             IN_VALID,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [WIDTH-1:0] D3,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  output logic [WIDTH-1:0] OUT,
  output logic             OUT_VALID,
  output logic [CNT_W-1:0] OUT_CNT
`ifdef S2_PIPE_PARITY_EN
  ,
  output logic             OUT_PAR
`endif
);

  logic [WIDTH-1:0] s1_s;
  logic [WIDTH-1:0] s0_s;
  logic [WIDTH-1:0] mux_s;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign s1_s = A1 | B1;
  assign s0_s = A0 & B0;

  // Per-lane select: {S1,S0} picks D0..D3 independently in every lane
  always_comb begin
    mux_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case ({s1_s[i], s0_s[i]})
        2'b00:   mux_s[i] = D0[i];
        2'b01:   mux_s[i] = D1[i];
        2'b10:   mux_s[i] = D2[i];
        2'b11:   mux_s[i] = D3[i];
        default: mux_s[i] = D0[i];
      endcase
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (EN) begin
      data_d[0]  = mux_s;
      valid_d[0] = IN_VALID;
      for (int k = 1; k < DEPTH; k++) begin
        data_d[k]  = data_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
      // valid_d of the last stage is exactly the word being delivered to OUT
      if (valid_d[DEPTH-1] && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      data_d  = data_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign OUT       = data_q[DEPTH-1];
  assign OUT_VALID = valid_q[DEPTH-1];
  assign OUT_CNT   = cnt_q;

`ifdef S2_PIPE_PARITY_EN
  logic [DEPTH-1:0] par_q;
  logic [DEPTH-1:0] par_d;

  function automatic logic parity_f(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction

  // Parity is taken at the mux and rides alongside its data word
  always_comb begin
    par_d = par_q;
    if (EN) begin
      par_d[0] = parity_f(mux_s);
      for (int k = 1; k < DEPTH; k++) begin
        par_d[k] = par_q[k-1];
      end
    end else begin
      par_d = par_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      par_q <= '0;
    end else begin
      par_q <= par_d;
    end
  end

  assign OUT_PAR = par_q[DEPTH-1];
`endif

endmodule

// File: tb/tb_s2_pipe.sv
// Self-checking bench for s2_pipe (WIDTH=8, DEPTH=2, CNT_W=4): directed scenarios
// plus a randomized run against a delay-line reference model.
module tb_s2_pipe;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic clk = 1'b0;
  logic clr, en, iv;
  logic [7:0] d0, d1, d2, d3, a1, b1, a0, b0;
  logic [7:0] out;
  logic       out_valid;
  logic [3:0] out_cnt;
`ifdef S2_PIPE_PARITY_EN
  logic       out_par;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       v;
  } ent_t;

  ent_t hist[$];
  int   mcnt;

  s2_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(clk), .CLR(clr), .EN(en), .IN_VALID(iv),
    .D0(d0), .D1(d1), .D2(d2), .D3(d3),
    .A1(a1), .B1(b1), .A0(a0), .B0(b0),
    .OUT(out), .OUT_VALID(out_valid), .OUT_CNT(out_cnt)
`ifdef S2_PIPE_PARITY_EN
    , .OUT_PAR(out_par)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_mux(input logic [7:0] w0, w1, w2, w3, p1, q1, p0, q0);
    logic [7:0] s1, s0;
    s1 = p1 | q1;
    s0 = p0 & q0;
    return (w0 & ~s1 & ~s0) | (w1 & ~s1 & s0) | (w2 & s1 & ~s0) | (w3 & s1 & s0);
  endfunction

  task automatic model_reset();
    ent_t z;
    z.data = 8'h00;
    z.v    = 1'b0;
    hist   = {};
    for (int i = 0; i < DEPTH; i++) hist.push_back(z);
    mcnt = 0;
  endtask

  // One clock edge; the model is a delay line of DEPTH enabled edges
  task automatic tick();
    ent_t e, old;
    @(posedge clk);
    if (clr) begin
      model_reset();
    end else if (en) begin
      e.data = ref_mux(d0, d1, d2, d3, a1, b1, a0, b0);
      e.v    = iv;
      hist.push_back(e);
      old = hist.pop_front();
      if (hist[0].v && mcnt < CMAX) mcnt++;
    end
    #1;
  endtask

  task automatic set_data(input logic [7:0] w0, w1, w2, w3);
    d0 = w0; d1 = w1; d2 = w2; d3 = w3;
  endtask

  task automatic set_sel(input logic [7:0] p1, q1, p0, q0);
    a1 = p1; b1 = q1; a0 = p0; b0 = q0;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; en = 1'b1; iv = 1'b1;
    set_data(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    set_sel(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    tick();
    tick();
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL reset_out got=%h exp=00", out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", out_cnt); end
`ifdef S2_PIPE_PARITY_EN
    checks++; if (out_par !== 1'b0) begin errors++; $display("FAIL reset_par got=%b exp=0", out_par); end
`endif
    clr = 1'b0;
  endtask

  task automatic test_all_ones();
    set_sel(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    set_data(8'h00, 8'h00, 8'h00, 8'hA5);
    en = 1'b1; iv = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ones_valid_e1 got=%b exp=0", out_valid); end
    iv = 1'b0;
    tick();
    checks++; if (out !== 8'hA5) begin errors++; $display("FAIL ones_out got=%h exp=a5", out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ones_valid_e2 got=%b exp=1", out_valid); end
    checks++; if (out_cnt !== 4'd1) begin errors++; $display("FAIL ones_cnt_e2 got=%0d exp=1", out_cnt); end
`ifdef S2_PIPE_PARITY_EN
    checks++; if (out_par !== 1'b0) begin errors++; $display("FAIL ones_par got=%b exp=0", out_par); end
`endif
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ones_valid_e3 got=%b exp=0", out_valid); end
    checks++; if (out_cnt !== 4'd1) begin errors++; $display("FAIL ones_cnt_e3 got=%0d exp=1", out_cnt); end
  endtask

  task automatic test_lane_mix();
    set_sel(8'hF0, 8'h00, 8'hCC, 8'hAA);
    en = 1'b1; iv = 1'b1;
    set_data(8'h00, 8'h00, 8'h00, 8'hFF);
    tick();
    set_data(8'hFF, 8'h00, 8'h00, 8'h00);
    tick();
    checks++; if (out !== 8'h80) begin errors++; $display("FAIL mix_d3 got=%h exp=80", out); end
    tick();
    checks++; if (out !== 8'h07) begin errors++; $display("FAIL mix_d0 got=%h exp=07", out); end
  endtask

  task automatic test_stall();
    do_clear();
    set_sel(8'h00, 8'h00, 8'h00, 8'h00);
    set_data(8'h11, 8'h00, 8'h00, 8'h00);
    en = 1'b1; iv = 1'b1;
    tick();
    d0 = 8'h22;
    tick();
    en = 1'b0; d0 = 8'h33;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out !== 8'h11 || out_valid !== 1'b1 || out_cnt !== 4'd1) begin
        errors++; $display("FAIL stall_hold[%0d] got=%h/%b/%0d exp=11/1/1", i, out, out_valid, out_cnt);
      end
    end
    en = 1'b1;
    tick();
    checks++; if (out !== 8'h22 || out_valid !== 1'b1 || out_cnt !== 4'd2) begin
      errors++; $display("FAIL stall_w2 got=%h/%b/%0d exp=22/1/2", out, out_valid, out_cnt);
    end
    iv = 1'b0;
    tick();
    checks++; if (out !== 8'h33 || out_valid !== 1'b1 || out_cnt !== 4'd3) begin
      errors++; $display("FAIL stall_w3 got=%h/%b/%0d exp=33/1/3", out, out_valid, out_cnt);
    end
    tick();
    checks++; if (out_valid !== 1'b0 || out_cnt !== 4'd3) begin
      errors++; $display("FAIL stall_end got=%b/%0d exp=0/3", out_valid, out_cnt);
    end
  endtask

  task automatic test_saturation();
    int exp_c;
    do_clear();
    en = 1'b1; iv = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      set_data($urandom, $urandom, $urandom, $urandom);
      set_sel($urandom, $urandom, $urandom, $urandom);
      tick();
      exp_c = (n - 1 > CMAX) ? CMAX : n - 1;
      checks++; if (out_cnt !== 4'(exp_c)) begin
        errors++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", n, out_cnt, exp_c);
      end
    end
    iv = 1'b0;
  endtask

  task automatic test_reset_midflight();
    do_clear();
    set_sel(8'h00, 8'h00, 8'h00, 8'h00);
    en = 1'b1; iv = 1'b1;
    set_data(8'h5A, 8'h00, 8'h00, 8'h00);
    tick();
    d0 = 8'hC3;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (out !== 8'h00 || out_valid !== 1'b0 || out_cnt !== 4'd0) begin
      errors++; $display("FAIL midclr got=%h/%b/%0d exp=00/0/0", out, out_valid, out_cnt);
    end
    iv = 1'b0; d0 = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (out !== 8'h00 || out_valid !== 1'b0) begin
        errors++; $display("FAIL midclr_after[%0d] got=%h/%b exp=00/0", i, out, out_valid);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clr = ($urandom_range(0, 39) == 0);
      en  = ($urandom_range(0, 9) < 7);
      iv  = $urandom_range(0, 1);
      set_data($urandom, $urandom, $urandom, $urandom);
      set_sel($urandom, $urandom, $urandom, $urandom);
      tick();
      checks++; if (out !== hist[0].data || out_valid !== hist[0].v || out_cnt !== 4'(mcnt)) begin
        errors++; $display("FAIL rand[%0d] got=%h/%b/%0d exp=%h/%b/%0d", i, out, out_valid, out_cnt,
                           hist[0].data, hist[0].v, mcnt);
      end
`ifdef S2_PIPE_PARITY_EN
      checks++; if (out_par !== ^hist[0].data) begin
        errors++; $display("FAIL rand_par[%0d] got=%b exp=%b", i, out_par, ^hist[0].data);
      end
`endif
    end
    clr = 1'b0;
  endtask

  initial begin
    clr = 1'b1; en = 1'b0; iv = 1'b0;
    set_data(8'h00, 8'h00, 8'h00, 8'h00);
    set_sel(8'h00, 8'h00, 8'h00, 8'h00);
    model_reset();
    test_reset();
    test_all_ones();
    test_lane_mix();
    test_stall();
    test_saturation();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
